// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR MAC sequencer.
//   - default geometry (sample/coefficient width, tap count, address width)
//   - default low-pass coefficient set loaded on reset
//   - FSM state enum and the output-width helper (2*N+4)
// Optional build macro used by the files importing this package: FIR_SYMM_EN.
package fir_pkg;

  localparam int unsigned DefN    = 17;
  localparam int unsigned DefTaps = 11;
  localparam int unsigned DefCw   = 17;
  localparam int unsigned DefAw   = 4;
  localparam int unsigned DefYw   = 2 * DefN + 4;

  localparam logic signed [DefCw-1:0] DefCoef [DefTaps] = '{
    17'sd124, -17'sd726, -17'sd2697, 17'sd2302, 17'sd18925, 17'sd29552,
    17'sd18925, 17'sd2302, -17'sd2697, -17'sd726, 17'sd124
  };

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  // Accumulator/output width: full 2N-bit product plus 4 guard bits for the tap sum.
  function automatic int unsigned yn_width(int unsigned n);
    return 2 * n + 4;
  endfunction

  // Default coefficient for tap i; taps beyond the default set reset to zero.
  function automatic logic signed [DefCw-1:0] def_coef(int unsigned i);
    if (i < DefTaps) return DefCoef[i];
    return '0;
  endfunction

endpackage

// File: rtl/fir_sample_ring.sv
// Circular sample buffer for the FIR sequencer.
//   clk, rst      : clock, synchronous active-high reset (clears entries and pointer)
//   we, wdata     : write one new sample at the write pointer, pointer advances mod TAPS
//   rd_off        : tap offset k; rd_data = x[n-k] relative to the newest sample
//   rd_off_b      : second offset port, present only with FIR_SYMM_EN (symmetric pre-add)
module fir_sample_ring #(
  parameter int unsigned N    = 17,
  parameter int unsigned TAPS = 11,
  parameter int unsigned AW   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic signed [N-1:0] wdata,
  input  logic [AW-1:0]       rd_off,
  output logic signed [N-1:0] rd_data
`ifdef FIR_SYMM_EN
  ,
  input  logic [AW-1:0]       rd_off_b,
  output logic signed [N-1:0] rd_data_b
`endif
);

  logic signed [N-1:0] buf_q [TAPS];
  logic [AW-1:0]       wr_ptr_q;
  logic [AW-1:0]       newest;

  // Wrap is modulo TAPS, not a power of two.
  function automatic logic [AW-1:0] tap_addr(logic [AW-1:0] nw, logic [AW-1:0] off);
    if (off <= nw) return nw - off;
    return nw + AW'(TAPS) - off;
  endfunction

  assign newest  = (wr_ptr_q == '0) ? AW'(TAPS - 1) : wr_ptr_q - 1'b1;
  assign rd_data = buf_q[tap_addr(newest, rd_off)];
`ifdef FIR_SYMM_EN
  assign rd_data_b = buf_q[tap_addr(newest, rd_off_b)];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < TAPS; i++) buf_q[i] <= '0;
      wr_ptr_q <= '0;
    end else if (we) begin
      buf_q[wr_ptr_q] <= wdata;
      wr_ptr_q        <= (wr_ptr_q == AW'(TAPS - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller: accepts one sample (valid/ready), runs one shared
// signed MAC over the taps, then holds the result until the consumer takes it.
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid/in_ready/xn      : input sample handshake
//   out_valid/out_ready/yn    : filtered output handshake (yn is 2N+4 bits signed)
//   cfg_we/cfg_addr/cfg_data  : coefficient write, honoured only in IDLE with addr < TAPS
//   cfg_err                   : one-cycle pulse for a rejected coefficient write
//   busy                      : high while in MAC or OUT
// Build macro FIR_SYMM_EN: symmetric-coefficient pass of (TAPS+1)/2 cycles with a
// pre-add of mirrored samples; coefficient writes also update the mirror index.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int unsigned N    = DefN,
  parameter int unsigned TAPS = DefTaps,
  parameter int unsigned CW   = DefCw,
  parameter int unsigned AW   = DefAw
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    xn,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*N+3:0]  yn,
  input  logic            cfg_we,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [CW-1:0]   cfg_data,
  output logic            cfg_err,
  output logic            busy
);

  localparam int unsigned YW = yn_width(N);
`ifdef FIR_SYMM_EN
  localparam int unsigned KLast = (TAPS - 1) / 2;
  localparam int unsigned MW    = N + 1;
`else
  localparam int unsigned KLast = TAPS - 1;
  localparam int unsigned MW    = N;
`endif
  localparam int unsigned PW = MW + CW;

  state_e                 state_q;
  logic [AW-1:0]          k_q;
  logic signed [YW-1:0]   acc_q;
  logic signed [YW-1:0]   yn_q;
  logic                   in_ready_q, out_valid_q, cfg_err_q, busy_q;
  logic signed [CW-1:0]   coef_q [TAPS];

  logic signed [N-1:0]    tap_a;
  logic signed [MW-1:0]   mul_x;
  logic signed [PW-1:0]   prod;
  logic signed [YW-1:0]   mac_sum;
  logic                   accept;
  logic                   cfg_ok;

  assign accept = in_valid & in_ready_q;
  assign cfg_ok = (state_q == StIdle) && ({1'b0, cfg_addr} < (AW + 1)'(TAPS));

`ifdef FIR_SYMM_EN
  logic signed [N-1:0] tap_b;

  fir_sample_ring #(.N(N), .TAPS(TAPS), .AW(AW)) u_ring (
    .clk       (clk),
    .rst       (rst),
    .we        (accept),
    .wdata     (xn),
    .rd_off    (k_q),
    .rd_data   (tap_a),
    .rd_off_b  (AW'(TAPS - 1) - k_q),
    .rd_data_b (tap_b)
  );
`else
  fir_sample_ring #(.N(N), .TAPS(TAPS), .AW(AW)) u_ring (
    .clk     (clk),
    .rst     (rst),
    .we      (accept),
    .wdata   (xn),
    .rd_off  (k_q),
    .rd_data (tap_a)
  );
`endif

  always_comb begin
`ifdef FIR_SYMM_EN
    // Centre tap has no mirror partner.
    if (k_q == AW'(KLast)) mul_x = {tap_a[N-1], tap_a};
    else                   mul_x = {tap_a[N-1], tap_a} + {tap_b[N-1], tap_b};
`else
    mul_x = tap_a;
`endif
    prod    = PW'(coef_q[k_q]) * PW'(mul_x);
    mac_sum = acc_q + YW'(prod);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      k_q         <= '0;
      acc_q       <= '0;
      yn_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      for (int unsigned i = 0; i < TAPS; i++) coef_q[i] <= CW'(def_coef(i));
    end else begin
      cfg_err_q <= 1'b0;
      if (cfg_we) begin
        if (cfg_ok) begin
          coef_q[cfg_addr] <= cfg_data;
`ifdef FIR_SYMM_EN
          coef_q[AW'(TAPS - 1) - cfg_addr] <= cfg_data;
`endif
        end else begin
          cfg_err_q <= 1'b1;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q    <= StMac;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            acc_q      <= '0;
            k_q        <= '0;
          end
        end
        StMac: begin
          acc_q <= mac_sum;
          k_q   <= k_q + 1'b1;
          if (k_q == AW'(KLast)) begin
            yn_q        <= mac_sum;
            out_valid_q <= 1'b1;
            state_q     <= StOut;
          end
        end
        StOut: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign yn        = yn_q;
  assign cfg_err   = cfg_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: directed impulse/step/backpressure/config/
// reset/extreme cases followed by randomized samples and coefficient writes, all checked
// against a direct-convolution model. Honours FIR_SYMM_EN for latency and mirrored writes.
module tb_fir_mac_sequencer;

  localparam int TAPS = 11;
`ifdef FIR_SYMM_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 12;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] xn;
  logic        out_valid;
  logic        out_ready;
  logic [37:0] yn;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [16:0] cfg_data;
  logic        cfg_err;
  logic        busy;

  fir_mac_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .xn        (xn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .yn        (yn),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_err   (cfg_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  longint dcoef [TAPS] = '{124, -726, -2697, 2302, 18925, 29552, 18925, 2302, -2697, -726, 124};
  longint mcoef [TAPS];
  longint hist  [TAPS];
  int     n_cmp = 0;
  int     n_err = 0;
  int     lat;
  longint exp_y;
  logic signed [63:0] last_y;

  function automatic longint model_y();
    longint s = 0;
    for (int k = 0; k < TAPS; k++) s += mcoef[k] * hist[k];
    return s;
  endfunction

  function automatic void model_cfg(input int a, input longint v);
    mcoef[a] = v;
`ifdef FIR_SYMM_EN
    mcoef[TAPS - 1 - a] = v;
`endif
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < TAPS; k++) begin mcoef[k] = dcoef[k]; hist[k] = 0; end
  endtask

  task automatic cfg_write(input int a, input longint v, input bit exp_err);
    cfg_we = 1'b1; cfg_addr = 4'(a); cfg_data = 17'(v);
    @(negedge clk);
    cfg_we = 1'b0;
    chk("cfg_err", cfg_err, exp_err);
    if (!exp_err) model_cfg(a, v);
    else begin
      @(negedge clk);
      chk("cfg_err_one_cycle", cfg_err, 0);
    end
  endtask

  task automatic accept(input int x, input bit do_cfg, input int a, input longint v);
    int w = 0;
    while (in_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    chk("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1; xn = x[16:0];
    if (do_cfg) begin cfg_we = 1'b1; cfg_addr = 4'(a); cfg_data = 17'(v); end
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0;
    if (do_cfg) begin
      chk("cfg_with_accept_err", cfg_err, 0);
      model_cfg(a, v);
    end
    for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
    exp_y = model_y();
    lat = 1;
  endtask

  task automatic finish(input int hold, input bit early, input int nx);
    bit bad = 1'b0;
    logic [37:0] y0;
    out_ready = (hold == 0);
    while (out_valid !== 1'b1 && lat < 40) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, LAT);
    chk("mac_in_ready_busy", bad, 0);
    last_y = $signed(yn);
    chk("yn", last_y, exp_y);
    if (hold > 0) begin
      y0 = yn; bad = 1'b0;
      if (early) begin in_valid = 1'b1; xn = nx[16:0]; end
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (yn !== y0 || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
      end
      chk("hold_stable", bad, 0);
      out_ready = 1'b1;
      @(negedge clk);
      chk("release_out_valid", out_valid, 0);
      chk("release_in_ready", in_ready, 1);
    end else begin
      @(negedge clk);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; xn = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;

    // Reset state
    do_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_yn", yn, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_busy", busy, 0);

    // Impulse response equals the coefficient table, then zero
    for (int i = 0; i < 12; i++) begin
      accept((i == 0) ? 1 : 0, 1'b0, 0, 0);
      finish(0, 1'b0, 0);
      chk("impulse_tab", last_y, (i < TAPS) ? dcoef[i] : 0);
    end

    // Step response
    do_reset();
    for (int i = 0; i < TAPS; i++) begin
      accept(1000, 1'b0, 0, 0);
      finish(0, 1'b0, 0);
      if (i == 0)  chk("step_first", last_y, 124000);
      if (i == 10) chk("step_steady", last_y, 65408000);
    end

    // Backpressure with the next sample waiting during OUT
    accept(7, 1'b0, 0, 0);
    finish(20, 1'b1, -3);
    accept(-3, 1'b0, 0, 0);
    finish(0, 1'b0, 0);

    // Zero the centre coefficient, then impulse
    do_reset();
    cfg_write(5, 0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      accept((i == 0) ? 1 : 0, 1'b0, 0, 0);
      finish(0, 1'b0, 0);
      if (i == 5) chk("coef5_zero", last_y, 0);
    end

    // Rejected writes: during MAC and out-of-range address
    accept(3, 1'b0, 0, 0);
    cfg_we = 1'b1; cfg_addr = 4'd2; cfg_data = 17'd777;
    @(negedge clk); lat++;
    cfg_we = 1'b0;
    chk("cfg_mac_err", cfg_err, 1);
    @(negedge clk); lat++;
    chk("cfg_mac_err_one_cycle", cfg_err, 0);
    finish(0, 1'b0, 0);
    cfg_write(11, 5, 1'b1);
    accept(-9, 1'b0, 0, 0);
    finish(0, 1'b0, 0);

    // Write coincident with an accepted sample is used by that pass
    accept(2, 1'b1, 1, -1234);
    finish(0, 1'b0, 0);

    // Reset during MAC at k=4
    accept(5, 1'b0, 0, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < TAPS; k++) begin mcoef[k] = dcoef[k]; hist[k] = 0; end
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    for (int i = 0; i < 12; i++) begin
      accept((i == 0) ? 1 : 0, 1'b0, 0, 0);
      finish(0, 1'b0, 0);
      chk("midrst_impulse", last_y, (i < TAPS) ? dcoef[i] : 0);
    end

    // Most-negative input held
    do_reset();
    for (int i = 0; i < 12; i++) begin
      accept(-65536, 1'b0, 0, 0);
      finish(0, 1'b0, 0);
      if (i >= 10) chk("extreme_steady", last_y, -64'sd4286578688);
    end

    // Randomized samples, coefficient writes and backpressure
    for (int r = 0; r < 40; r++) begin
      int x;
      int a;
      longint v;
      x = int'($urandom_range(0, 131071)) - 65536;
      a = int'($urandom_range(0, TAPS - 1));
      v = longint'($urandom_range(0, 131071)) - 65536;
      if ($urandom_range(0, 3) == 0) cfg_write(a, v, 1'b0);
      a = int'($urandom_range(0, TAPS - 1));
      v = longint'($urandom_range(0, 131071)) - 65536;
      accept(x, ($urandom_range(0, 4) == 0), a, v);
      finish(int'($urandom_range(0, 2)), 1'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
